// File: rtl/avl_master_engine.sv
// Avalon-MM initiator: queued commands -> single bus transfers, one response each, one outstanding at a time.
// Request follows command push by 1 edge; response is held until rsp_ready. Optional AVL_MASTER_ALIGN_CHECK_EN rejects misaligned addresses.
module avl_master_engine #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_write,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic [31:0] address,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic        read,
  output logic        write,
  input  logic [31:0] readdata,
  input  logic        waitrequest
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_M1 = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t        state, state_nxt;
  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [CW-1:0] wait_cnt;
  logic          push, pop, full, empty;
  logic          issue, done, abort, misalign;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign head      = mem[rd_ptr];
  assign busy      = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata, be: cmd_be};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    issue     = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    misalign  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
`ifdef AVL_MASTER_ALIGN_CHECK_EN
          if (head.addr[1:0] != 2'b00) begin
            misalign  = 1'b1;
            state_nxt = RESP;
          end else
`endif
          begin
            issue     = 1'b1;
            state_nxt = BUS;
          end
        end
      end
      BUS: begin
        if (!waitrequest) begin
          done      = 1'b1;
          state_nxt = RESP;
        end else if ((TIMEOUT != 0) && (wait_cnt == CW'(TO_M1))) begin
          abort     = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // While in BUS, 'write' still holds the command type, so it feeds rsp_write directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      address    <= '0;
      byteenable <= '0;
      writedata  <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      wait_cnt   <= '0;
      rsp_valid  <= 1'b0;
      rsp_write  <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (issue) begin
        address    <= head.addr;
        byteenable <= head.be;
        writedata  <= head.wdata;
        read       <= !head.write;
        write      <= head.write;
        wait_cnt   <= '0;
      end
      if ((state == BUS) && waitrequest && (TIMEOUT != 0)) wait_cnt <= wait_cnt + 1'b1;
      if (done || abort) begin
        read      <= 1'b0;
        write     <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_write <= write;
        rsp_data  <= (done && !write) ? readdata : 32'h0;
        rsp_err   <= abort;
      end
      if (misalign) begin
        rsp_valid <= 1'b1;
        rsp_write <= head.write;
        rsp_data  <= 32'h0;
        rsp_err   <= 1'b1;
      end
      if ((state == RESP) && rsp_ready) rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_avl_master_engine.sv
// Directed bench for avl_master_engine (DEPTH=4, TIMEOUT=8) with a small word-addressed slave memory.
module tb_avl_master_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_be;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_err, busy;
  logic [31:0] rsp_data;
  logic [31:0] address, writedata, readdata;
  logic [3:0]  byteenable;
  logic        read, write, waitrequest;

  int n_checks = 0;
  int n_fail   = 0;
  int rd_cycles = 0, wr_cycles = 0, both_cnt = 0, overlap_cnt = 0;
  logic [31:0] smem [16];

  always #5 clk = ~clk;

  avl_master_engine #(.DEPTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .address(address), .byteenable(byteenable), .writedata(writedata),
    .read(read), .write(write), .readdata(readdata), .waitrequest(waitrequest)
  );

  // Slave memory: word i resets to 0xC0DE0000+i, byte-enabled writes complete when waitrequest=0.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) smem[i] <= 32'hC0DE_0000 + 32'(i);
    end else if (write && !waitrequest) begin
      for (int b = 0; b < 4; b++)
        if (byteenable[b]) smem[address[5:2]][8*b +: 8] <= writedata[8*b +: 8];
    end
  end
  assign readdata = smem[address[5:2]];

  always @(posedge clk) begin
    if (read) rd_cycles <= rd_cycles + 1;
    if (write) wr_cycles <= wr_cycles + 1;
    if (read && write) both_cnt <= both_cnt + 1;
    if ((read || write) && rsp_valid) overlap_cnt <= overlap_cnt + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // Stimulus helpers: called at a negedge, return at a negedge.
  task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    int t;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_be = be;
    t = 0;
    while (!cmd_ready && t < 200) begin @(negedge clk); t++; end
    if (!cmd_ready) begin
      n_checks++; n_fail++;
      $display("FAIL push_timeout: cmd_ready got 0 want 1 within 200 cycles");
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int t;
    t = 0;
    while (!rsp_valid && t < 200) begin @(negedge clk); t++; end
    if (!rsp_valid) begin
      n_checks++; n_fail++;
      $display("FAIL rsp_timeout: rsp_valid got 0 want 1 within 200 cycles");
    end
  endtask

  task automatic accept_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if ({read, write, busy, rsp_valid, rsp_err, rsp_write} !== 6'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 000000", {read, write, busy, rsp_valid, rsp_err, rsp_write}); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    n_checks++; if ({address, byteenable, writedata, rsp_data} !== 100'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", {address, byteenable, writedata, rsp_data}); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if ({busy, read, write} !== 3'b000) begin n_fail++; $display("FAIL post_reset_idle: got %b want 000", {busy, read, write}); end
  endtask

  task automatic test_write_read();
    int w0;
    waitrequest = 1'b0;
    w0 = wr_cycles;
    push_cmd(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk);
    n_checks++; if ({write, read, address, writedata, byteenable} !== {2'b10, 32'h10, 32'hDEAD_BEEF, 4'hF}) begin n_fail++; $display("FAIL wr_request: got w=%b r=%b a=%h d=%h be=%h want w=1 r=0 a=10 d=deadbeef be=f", write, read, address, writedata, byteenable); end
    @(negedge clk);
    n_checks++; if ({rsp_valid, write, rsp_write, rsp_err, rsp_data} !== {4'b1010, 32'h0}) begin n_fail++; $display("FAIL wr_response: got v=%b w=%b rw=%b e=%b d=%h want v=1 w=0 rw=1 e=0 d=0", rsp_valid, write, rsp_write, rsp_err, rsp_data); end
    n_checks++; if (wr_cycles - w0 != 1) begin n_fail++; $display("FAIL wr_pulse_len: got %0d want 1", wr_cycles - w0); end
    accept_rsp();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rsp_release: got %b want 0", rsp_valid); end
    push_cmd(1'b0, 32'h10, 32'h0, 4'hF);
    wait_rsp();
    n_checks++; if ({rsp_write, rsp_err, rsp_data} !== {2'b00, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL rd_after_wr: got rw=%b e=%b d=%h want rw=0 e=0 d=deadbeef", rsp_write, rsp_err, rsp_data); end
    accept_rsp();
  endtask

  task automatic test_waitrequest();
    int stable;
    waitrequest = 1'b1;
    push_cmd(1'b0, 32'h14, 32'h0, 4'hF);
    @(negedge clk);
    stable = 0;
    for (int i = 0; i < 6; i++) begin
      if (read && !write && address == 32'h14 && byteenable == 4'hF && !rsp_valid) stable++;
      if (i == 5) waitrequest = 1'b0;
      @(negedge clk);
    end
    n_checks++; if (stable != 6) begin n_fail++; $display("FAIL wait_stable_cycles: got %0d want 6", stable); end
    n_checks++; if ({read, rsp_valid, rsp_err, rsp_data} !== {3'b010, 32'hC0DE_0005}) begin n_fail++; $display("FAIL wait_rsp: got r=%b v=%b e=%b d=%h want r=0 v=1 e=0 d=c0de0005", read, rsp_valid, rsp_err, rsp_data); end
    accept_rsp();
  endtask

  task automatic test_fifo_full();
    logic [31:0] addrs [5];
    logic [31:0] exp [5];
    int k;
    addrs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10};
    exp   = '{32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003, 32'hDEAD_BEEF};
    waitrequest = 1'b0;
    push_cmd(1'b0, addrs[0], 32'h0, 4'hF);
    wait_rsp();
    for (int i = 1; i < 5; i++) push_cmd(1'b0, addrs[i], 32'h0, 4'hF);
    n_checks++; if ({cmd_ready, busy} !== 2'b01) begin n_fail++; $display("FAIL fifo_full: got ready=%b busy=%b want ready=0 busy=1", cmd_ready, busy); end
    n_checks++; if ({rsp_valid, read, rsp_data} !== {2'b10, 32'hC0DE_0000}) begin n_fail++; $display("FAIL rsp_hold: got v=%b r=%b d=%h want v=1 r=0 d=c0de0000", rsp_valid, read, rsp_data); end
    rsp_ready = 1'b1;
    k = 0;
    for (int t = 0; t < 60 && k < 5; t++) begin
      if (rsp_valid) begin
        n_checks++; if ({rsp_err, rsp_data} !== {1'b0, exp[k]}) begin n_fail++; $display("FAIL fifo_order_%0d: got e=%b d=%h want e=0 d=%h", k, rsp_err, rsp_data, exp[k]); end
        k++;
      end
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    n_checks++; if (k != 5) begin n_fail++; $display("FAIL fifo_rsp_count: got %0d want 5", k); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fifo_busy_drop: got %b want 0", busy); end
  endtask

  task automatic test_timeout();
    int hi;
    waitrequest = 1'b1;
    push_cmd(1'b0, 32'h00, 32'h0, 4'hF);
    push_cmd(1'b1, 32'h08, 32'h55AA_55AA, 4'b0011);
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      if (read) hi++;
      @(negedge clk);
    end
    n_checks++; if (hi != 8) begin n_fail++; $display("FAIL to_request_cycles: got %0d want 8", hi); end
    n_checks++; if ({read, rsp_valid, rsp_err, rsp_write, rsp_data} !== {4'b0110, 32'h0}) begin n_fail++; $display("FAIL to_abort: got r=%b v=%b e=%b rw=%b d=%h want r=0 v=1 e=1 rw=0 d=0", read, rsp_valid, rsp_err, rsp_write, rsp_data); end
    waitrequest = 1'b0;
    accept_rsp();
    wait_rsp();
    n_checks++; if ({rsp_write, rsp_err, rsp_data} !== {2'b10, 32'h0}) begin n_fail++; $display("FAIL to_next_cmd: got rw=%b e=%b d=%h want rw=1 e=0 d=0", rsp_write, rsp_err, rsp_data); end
    accept_rsp();
    n_checks++; if (smem[2] !== 32'hC0DE_55AA) begin n_fail++; $display("FAIL to_next_write_data: got %h want c0de55aa", smem[2]); end
  endtask

  task automatic test_reset_mid();
    int r0, seen;
    waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) push_cmd(1'b0, 32'(4 * i), 32'h0, 4'hF);
    n_checks++; if ({read, busy} !== 2'b11) begin n_fail++; $display("FAIL rm_in_bus: got r=%b busy=%b want r=1 busy=1", read, busy); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({read, write, busy, rsp_valid, cmd_ready} !== 5'b00001) begin n_fail++; $display("FAIL rm_async: got %b want 00001", {read, write, busy, rsp_valid, cmd_ready}); end
    @(negedge clk);
    rst = 1'b0;
    waitrequest = 1'b0;
    r0 = rd_cycles;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid || busy) seen++;
    end
    n_checks++; if (seen != 0 || rd_cycles != r0) begin n_fail++; $display("FAIL rm_discard: got active=%0d reads=%0d want 0 0", seen, rd_cycles - r0); end
  endtask

  task automatic test_align();
    int r0;
    waitrequest = 1'b0;
    r0 = rd_cycles;
    push_cmd(1'b0, 32'h13, 32'h0, 4'hF);
`ifdef AVL_MASTER_ALIGN_CHECK_EN
    wait_rsp();
    n_checks++; if ({rsp_err, rsp_write, rsp_data} !== {2'b10, 32'h0}) begin n_fail++; $display("FAIL align_err: got e=%b rw=%b d=%h want e=1 rw=0 d=0", rsp_err, rsp_write, rsp_data); end
    n_checks++; if (rd_cycles != r0) begin n_fail++; $display("FAIL align_no_read: got %0d want 0", rd_cycles - r0); end
`else
    @(negedge clk);
    n_checks++; if ({read, address} !== {1'b1, 32'h13}) begin n_fail++; $display("FAIL align_pass: got r=%b a=%h want r=1 a=13", read, address); end
    wait_rsp();
    n_checks++; if ({rsp_err, rsp_data} !== {1'b0, 32'hC0DE_0004}) begin n_fail++; $display("FAIL align_data: got e=%b d=%h want e=0 d=c0de0004", rsp_err, rsp_data); end
`endif
    accept_rsp();
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_be = '0;
    rsp_ready = 1'b0; waitrequest = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_write_read();
    test_waitrequest();
    test_fifo_full();
    test_timeout();
    test_reset_mid();
    test_align();
    n_checks++; if (both_cnt != 0 || overlap_cnt != 0) begin n_fail++; $display("FAIL protocol: got both=%0d overlap=%0d want 0 0", both_cnt, overlap_cnt); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
